alu_cmd_sequencer: RTL
======================

// Module: alu_cmd_sequencer
// PURPOSE
//   Drives the datapath ALU from a valid/ready command stream. It is the issuing end of the
//   alu_a/alu_b/alu_op -> alu_out interface.
//   Each command {a, b, op} is latched onto the ALU inputs and held for SETTLE_CYC cycles.
//   alu_out is then captured and returned on a valid/ready response port.
//   Sits between the control/test front-end and the combinational ALU.
// PARAMETERS
//   WIDTH       32  operand/result width
//   OP_W        5   ALU opcode width
//   SETTLE_CYC  1   cycles alu_out is allowed to settle before capture (legal range >=1)
//   COUNT_W     16  width of completed-operation counter
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        reset, asynchronous, active-high
//   cmd_valid  in   1        command present
//   cmd_ready  out  1        sequencer can accept command
//   cmd_a      in   WIDTH    operand A
//   cmd_b      in   WIDTH    operand B
//   cmd_op     in   OP_W     ALU opcode
//   alu_a      out  WIDTH    to ALU operand A (registered)
//   alu_b      out  WIDTH    to ALU operand B (registered)
//   alu_op     out  OP_W     to ALU opcode (registered)
//   alu_out    in   WIDTH    from ALU result (combinational)
//   rsp_valid  out  1        result available
//   rsp_ready  in   1        consumer takes result
//   rsp_data   out  WIDTH    captured ALU result
//   rsp_op     out  OP_W     opcode that produced rsp_data
//   busy       out  1        state != IDLE
//   op_count   out  COUNT_W  completed (handshaken) responses, wraps
// BEHAVIOUR
//   - Reset values (immediate on rst, no clock needed):
//     state=IDLE; alu_a/alu_b/alu_op=0; rsp_valid=0; rsp_data=0; rsp_op=0; op_count=0.
//   - cmd_ready = (state==IDLE). busy = (state!=IDLE). Both are combinational from state.
//   - FSM, states IDLE, WAIT, RESP:
//     IDLE: on cmd_valid&cmd_ready, register cmd_a/b/op into alu_a/b/op.
//           Load settle counter with SETTLE_CYC, then go to WAIT. cmd_* are sampled only at this handshake.
//     WAIT: the counter decrements each cycle. On the cycle it reaches 1:
//           rsp_data <= alu_out, rsp_op <= alu_op, rsp_valid <= 1, go to RESP.
//     RESP: rsp_data and rsp_op are held stable while rsp_valid=1.
//           On rsp_valid&rsp_ready: rsp_valid <= 0, op_count <= op_count+1, go to IDLE.
//   - Latency: accept at edge N; alu_* valid after edge N.
//     Capture at edge N+SETTLE_CYC; rsp_valid is high from that edge.
//     Minimum issue interval is SETTLE_CYC+2 cycles.
//   - alu_a/b/op retain the last command after the response, so the ALU inputs stay stable.
//     They change only at the IDLE accept.
//   - cmd_valid outside IDLE is ignored, with no side effect. The command must be held by
//     the source until cmd_ready.
//   - rsp_ready while rsp_valid=0 is ignored.
//   - A command is never accepted in the same cycle as a response handshake. The next accept
//     is the first IDLE cycle.
//   - op_count wraps all-ones -> 0, with no flag.
//   - Widths: rsp_data = alu_out exactly, no extension or truncation.
//   - rst asserted mid-WAIT or mid-RESP aborts the operation. The pending result is lost and
//     no response is issued. All outputs return to their reset values.
// TESTING (bench uses behavioural ALU model: op 5'h01 = add, 5'h02 = sub)
//   1. rst, then cmd a=2 b=2 op=01 (SETTLE_CYC=1, rsp_ready=1)
//      -> alu_a=2, alu_b=2, alu_op=01 after accept; rsp_valid one edge later;
//         rsp_data=4, rsp_op=01, op_count=1.
//   2. cmd a=7 b=3 op=02, rsp_ready=0 for 5 cycles
//      -> rsp_valid=1, rsp_data=4 stable all 5 cycles; cmd_ready=0;
//         a second cmd_valid is not accepted; accepted only after the rsp handshake.
//   3. SETTLE_CYC=3; the model delays alu_out by 2 cycles, with junk before that
//      -> capture exactly 3 edges after accept; rsp_data is the correct sum, never junk.
//   4. Assert rst asynchronously (between edges) during WAIT
//      -> rsp_valid, alu_*, and op_count are 0 immediately; no response follows; cmd_ready=1.
//   5. COUNT_W=4; run 16 back-to-back add ops with cmd_valid and rsp_ready held high
//      -> op_count reaches 15, then 0; each accept is spaced SETTLE_CYC+2 cycles apart.
//   6. a=32'hFFFFFFFF b=1 op=01
//      -> rsp_data=0 (wraps at WIDTH); alu_* hold FFFFFFFF/1/01 in IDLE after the response.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU drive and response signals between the sequencer and its front-end/ALU.
// master = sequencer side, slave = front-end and ALU side.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH   = 32,
    parameter int OP_W    = 5,
    parameter int COUNT_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [WIDTH-1:0]   cmd_a;
    logic [WIDTH-1:0]   cmd_b;
    logic [OP_W-1:0]    cmd_op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [OP_W-1:0]    alu_op;
    logic [WIDTH-1:0]   alu_out;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_data;
    logic [OP_W-1:0]    rsp_op;
    logic               busy;
    logic [COUNT_W-1:0] op_count;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_op, busy, op_count
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_op, busy, op_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issues one valid/ready command at a time onto a combinational ALU, waits for the
// result to settle, then returns the captured result on a valid/ready response port.
//
// state | meaning
// IDLE  | ready for a command; ALU inputs hold the previous command
// WAIT  | ALU inputs applied, settle counter running down
// RESP  | result captured, waiting for the consumer to take it
module alu_cmd_sequencer #(
    parameter int WIDTH      = 32,
    parameter int OP_W       = 5,
    parameter int SETTLE_CYC = 1,
    parameter int COUNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.master bus
);
    localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_op   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_op   <= '0;
            bus.op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.alu_a  <= bus.cmd_a;
                        bus.alu_b  <= bus.cmd_b;
                        bus.alu_op <= bus.cmd_op;
                        settle_cnt <= CNT_W'(SETTLE_CYC);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // terminal count of 1 puts the capture SETTLE_CYC edges after the accept
                    if (settle_cnt == CNT_W'(1)) begin
                        bus.rsp_data  <= bus.alu_out;
                        bus.rsp_op    <= bus.alu_op;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.op_count  <= bus.op_count + COUNT_W'(1);
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
